// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential ALU: the opcode encoding, the control FSM
// state type, and a helper that classifies opcodes handled by the shift unit.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_DECAC = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_ASR   = 3'd4,
        OP_ADD   = 3'd5,
        OP_SUB   = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return op inside {OP_SHR, OP_SHL, OP_ASR};
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// -----------------------------------------------------------------------------
// alu_shift_unit
// Bit-serial shifter: holds the working register, the shift mode and a
// down-counter of remaining one-bit steps.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      capture i_data/i_mode/i_amount (start of a shift operation)
//   i_mode      shift kind (OP_SHR, OP_SHL, OP_ASR)
//   i_data      value to shift
//   i_amount    number of one-bit steps
//   i_step      perform one step this cycle (while the counter is non-zero)
//   o_next      working register after one more step
//   o_last      the coming step is the final one
// -----------------------------------------------------------------------------
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  op_e                i_mode,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_amount,
    input  logic               i_step,
    output logic [WIDTH-1:0]   o_next,
    output logic               o_last
);

    logic [WIDTH-1:0]   r_work;
    op_e                r_mode;
    logic [SHAMT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the working register is reset as well, so nothing downstream
    // ever observes X after reset, even though its value is reloaded on use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_mode  <= OP_NOP;
            r_count <= '0;
        end else if (i_load) begin
            r_work  <= i_data;
            r_mode  <= i_mode;
            r_count <= i_amount;
        end else if (i_step && (r_count != '0)) begin
            r_work  <= o_next;
            r_count <= r_count - SHAMT_W'(1);
        end
    end

    // NOTE: o_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_next = r_work;
        case (r_mode)
            OP_SHR:  o_next = {1'b0, r_work[WIDTH-1:1]};
            OP_SHL:  o_next = {r_work[WIDTH-2:0], 1'b0};
            OP_ASR:  o_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: o_next = r_work;
        endcase
    end

    assign o_last = (r_count == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU with valid/ready handshakes. Arithmetic ops complete in one
// cycle; shifts run bit-serially in alu_shift_unit, one bit per cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only when idle)
//   op, a, b            opcode and operands (b[SHAMT_W-1:0] = shift amount)
//   out_valid/out_ready result handshake (result held until accepted)
//   result, z, n        registered result, zero flag, borrow/negative flag
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n
);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_z;
    logic               r_n;

    logic [WIDTH-1:0]   w_result_next;
    logic               w_z_next;
    logic               w_n_next;

    op_e                w_op;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_amount;
    logic               w_shift_start;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_dec;
    logic [WIDTH-1:0]   w_arith_result;
    logic               w_arith_z;
    logic               w_arith_n;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_shift_last;

    assign w_op          = op_e'(op);
    assign w_accept      = in_valid && r_in_ready;
    assign w_amount      = b[SHAMT_W-1:0];
    assign w_shift_start = w_accept && is_shift_op(w_op) && (w_amount != '0);
    assign w_sum         = {1'b0, a} + {1'b0, b};
    assign w_dec         = a - WIDTH'(1);

    // Single-cycle results. A shift by zero also finishes here with result=a.
    always_comb begin
        w_arith_result = a;
        w_arith_z      = 1'b0;
        w_arith_n      = 1'b0;
        case (w_op)
            OP_DECAC: begin
                w_arith_result = w_dec;
                w_arith_z      = (w_dec == '0);
                w_arith_n      = (a == '0);
            end
            OP_SHR, OP_SHL, OP_ASR: begin
                w_arith_z = (a == '0);
            end
            OP_ADD: begin
                w_arith_result = w_sum[WIDTH-1:0];
                w_arith_z      = (w_sum[WIDTH-1:0] == '0);
                w_arith_n      = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_arith_result = (a < b) ? (b - a) : (a - b);
                w_arith_z      = (a == b);
                w_arith_n      = (a < b);
            end
            default: ; // NOP and reserved pass a through with clear flags
        endcase
    end

    alu_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_shift_start),
        .i_mode   (w_op),
        .i_data   (a),
        .i_amount (w_amount),
        .i_step   (r_state == ST_SHIFT),
        .o_next   (w_shift_next),
        .o_last   (w_shift_last)
    );

    // Next-state and next-output logic for the control FSM.
    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_z_next      = r_z;
        w_n_next      = r_n;
        case (r_state)
            ST_IDLE: begin
                if (w_shift_start) begin
                    w_state_next = ST_SHIFT;
                end else if (w_accept) begin
                    w_state_next  = ST_DONE;
                    w_result_next = w_arith_result;
                    w_z_next      = w_arith_z;
                    w_n_next      = w_arith_n;
                end
            end
            ST_SHIFT: begin
                // Capture the final step's value directly into the result flop.
                if (w_shift_last) begin
                    w_state_next  = ST_DONE;
                    w_result_next = w_shift_next;
                    w_z_next      = (w_shift_next == '0);
                    w_n_next      = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode so
    // they stay glitch-free and read correctly during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            r_result    <= w_result_next;
            r_z         <= w_z_next;
            r_n         <= w_n_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign z         = r_z;
    assign n         = r_n;

endmodule
